// File: rtl/key_in_pkg.sv
// key_in shared definitions: bus direction codes and register offsets.
// No ports; imported by every key_in file and by the bench.
package key_in_pkg;

    // ctrl encoding on the shared CPU bus
    localparam logic IO_CTRL_READ  = 1'b1;
    localparam logic IO_CTRL_WRITE = 1'b0;

    // register offsets, only addr[0] is decoded
    localparam logic KEY_REG_STATUS = 1'b0;
    localparam logic KEY_REG_EVENT  = 1'b1;

endpackage

// File: rtl/key_in_if.sv
// key_in_if: CPU bus control group (grant, address, direction).
// master drives EN/addr/ctrl, slave (the device) samples them.
interface key_in_if #(
    parameter int CPU_WIDTH = 16
);
    logic                 EN;
    logic [CPU_WIDTH-1:0] addr;
    logic                 ctrl;

    modport master (
        output EN,
        output addr,
        output ctrl
    );

    modport slave (
        input EN,
        input addr,
        input ctrl
    );
endinterface

// File: rtl/key_in_debounce.sv
// key_debounce: 2-flop synchronizer, debounce counter, accepted level.
// Ports: clk, rst_n, key_raw (active-low), level (accepted), press (pulse).
module key_debounce #(
    parameter int DEB_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          hit;

    // the changed level has held long enough; accept on this edge
    assign hit   = (s2 != level) && (cnt == LAST);
    // same edge the accepted level goes released -> pressed
    assign press = hit && !s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            s1 <= key_raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (hit) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/key_in.sv
// key_in: debounced key inputs with STATUS and sticky EVENT registers.
// Ports: clk, rst_n, bus (EN/addr/ctrl), data (tristate), key (active-low).
module key_in
    import key_in_pkg::*;
#(
    parameter int CPU_WIDTH  = 16,
    parameter int KEY_NUM    = 4,
    parameter int DEB_CYCLES = 20000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    key_in_if.slave              bus,
    inout  wire  [CPU_WIDTH-1:0] data,
    input  logic [KEY_NUM-1:0]   key
);
    logic                 read_call;
    logic                 write_call;
    logic                 sel_event;
    logic                 rd_event;
    logic [KEY_NUM-1:0]   level;
    logic [KEY_NUM-1:0]   press;
    logic [KEY_NUM-1:0]   flags;
    logic [KEY_NUM-1:0]   clr_mask;
    logic [KEY_NUM-1:0]   rd_snap;
    logic                 rd_ev_q;
    logic [CPU_WIDTH-1:0] rd_data;

    assign read_call  = bus.EN && (bus.ctrl == IO_CTRL_READ);
    assign write_call = bus.EN && (bus.ctrl == IO_CTRL_WRITE);
    assign sel_event  = (bus.addr[0] == KEY_REG_EVENT);
    assign rd_event   = read_call && sel_event;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        key_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .key_raw (key[i]),
            .level   (level[i]),
            .press   (press[i])
        );
    end

    always_comb begin
        rd_data = '0;
        if (sel_event) begin
            rd_data[KEY_NUM-1:0] = flags;
        end else begin
            rd_data[KEY_NUM-1:0] = ~level;
        end
    end

    assign data = read_call ? rd_data : {CPU_WIDTH{1'bz}};

    // An EVENT access ends on the first cycle that is not an EVENT read;
    // only the flags seen in its final cycle are cleared.
    always_comb begin
        clr_mask = '0;
        if (rd_ev_q && !rd_event) begin
            clr_mask = rd_snap;
        end
        if (write_call && sel_event) begin
            clr_mask = clr_mask | data[KEY_NUM-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags   <= '0;
            rd_snap <= '0;
            rd_ev_q <= 1'b0;
        end else begin
            rd_ev_q <= rd_event;
            if (rd_event) begin
                rd_snap <= flags;
            end
            // a press on the clearing edge survives
            flags <= (flags & ~clr_mask) | press;
        end
    end

    wire unused_ok = &{1'b0, bus.addr, data};
endmodule
